// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   // Counter value of the final restoring step
   localparam logic [CNT_W-1:0]  CNT_LAST     = 6'd31;
   // Quotient reported for a zero divisor
   localparam logic [DATA_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

   // 2'b11 is unused and treated as idle
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DIVIDE = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   // Two's-complement negate when en is set, pass through otherwise
   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
      return en ? (~v + DATA_W'(1)) : v;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
module div_step
   import seq_divider_pkg::*;
(
   input  logic [DATA_W-1:0] rem_in,
   input  logic              q_msb,
   input  logic [DATA_W-1:0] dvsr,
   output logic [DATA_W-1:0] rem_out,
   output logic              q_bit
);

   logic [DATA_W:0]   shifted;
   logic [DATA_W+1:0] sum;
   logic              unused_top;

   // Full partial remainder is shifted so divisors above 2^31 stay exact;
   // subtract as add of the inverted divisor with carry-in 1, carry-out = no borrow
   always_comb begin
      shifted = {rem_in, q_msb};
      sum     = {1'b0, shifted} + {1'b0, ~{1'b0, dvsr}} + (DATA_W+2)'(1);
      q_bit   = sum[DATA_W+1];
      rem_out = q_bit ? sum[DATA_W-1:0] : shifted[DATA_W-1:0];
   end

   // Bit 32 of either candidate is zero whenever it is selected
   assign unused_top = &{1'b0, sum[DATA_W], shifted[DATA_W]};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-cycle radix-2 divider, signed operands when DIV_SIGNED_EN is defined
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              op_start,
   input  logic              op_clear,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              op_done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem_r;
   logic [DATA_W-1:0] q_r;
   logic [DATA_W-1:0] dvsr_r;
   logic              neg_q;
   logic              neg_r;

   logic              in_idle;
   logic              div_zero;
   logic [DATA_W-1:0] dividend_mag;
   logic [DATA_W-1:0] divisor_mag;
   logic              start_neg_q;
   logic              start_neg_r;
   logic [DATA_W-1:0] step_rem;
   logic              step_qbit;
   logic [DATA_W-1:0] q_next;

   assign in_idle  = (state != ST_DIVIDE) && (state != ST_DONE);
   assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
   // Magnitudes and result signs are fixed at the start edge
   always_comb begin
      dividend_mag = neg_if(dividend, dividend[DATA_W-1]);
      divisor_mag  = neg_if(divisor, divisor[DATA_W-1]);
      start_neg_q  = dividend[DATA_W-1] ^ divisor[DATA_W-1];
      start_neg_r  = dividend[DATA_W-1];
   end
`else
   // Unsigned operands are their own magnitudes; no sign correction
   always_comb begin
      dividend_mag = dividend;
      divisor_mag  = divisor;
      start_neg_q  = 1'b0;
      start_neg_r  = 1'b0;
   end
`endif

   div_step u_step (
      .rem_in  (rem_r),
      .q_msb   (q_r[DATA_W-1]),
      .dvsr    (dvsr_r),
      .rem_out (step_rem),
      .q_bit   (step_qbit)
   );

   assign q_next = {q_r[DATA_W-2:0], step_qbit};

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and status decode; clear wins over start
   always_comb begin
      state_nxt = ST_IDLE;
      busy      = 1'b0;
      op_done   = 1'b0;
      if (in_idle) begin
         if (op_start && !op_clear) begin
            state_nxt = div_zero ? ST_DONE : ST_DIVIDE;
         end
      end else if (state == ST_DIVIDE) begin
         busy = 1'b1;
         if (op_clear) begin
            state_nxt = ST_IDLE;
         end else if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
         end else begin
            state_nxt = ST_DIVIDE;
         end
      end else begin
         op_done   = 1'b1;
         state_nxt = op_clear ? ST_IDLE : ST_DONE;
      end
   end

   // Operand latch, iteration registers and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dvsr_r      <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else if (in_idle) begin
         if (op_start && !op_clear) begin
            if (div_zero) begin
               div_by_zero <= 1'b1;
               quotient    <= DBZ_QUOTIENT;
               remainder   <= dividend;
            end else begin
               cnt    <= '0;
               rem_r  <= '0;
               q_r    <= dividend_mag;
               dvsr_r <= divisor_mag;
               neg_q  <= start_neg_q;
               neg_r  <= start_neg_r;
            end
         end
      end else if (op_clear) begin
         cnt         <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dvsr_r      <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else if (state == ST_DIVIDE) begin
         rem_r <= step_rem;
         q_r   <= q_next;
         cnt   <= cnt + CNT_W'(1);
         if (cnt == CNT_LAST) begin
            quotient  <= neg_if(q_next, neg_q);
            remainder <= neg_if(step_rem, neg_r);
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider, both DIV_SIGNED_EN builds
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        op_start = 1'b0;
   logic        op_clear = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        op_done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int          n_checks = 0;
   int          n_fail = 0;

   logic        exp_valid = 1'b0;
   logic [31:0] exp_q = '0;
   logic [31:0] exp_r = '0;
   logic        exp_dbz = 1'b0;

   seq_divider dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .op_done     (op_done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Arithmetic reference: truncating division, remainder follows the dividend
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z);
      longint sa;
      longint sb;
      longint lq;
      longint lr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         z = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = longint'($signed(a));
         sb = longint'($signed(b));
`else
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
`endif
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
         z  = 1'b0;
      end
   endfunction

   // Every cycle: a finished result must match the model, an idle divider shows zeros
   always @(negedge clk) begin
      if (reset_n) begin
         if (op_done) begin
            check("done_has_operation", 32'(exp_valid), 32'd1);
            check("done_quotient", quotient, exp_q);
            check("done_remainder", remainder, exp_r);
            check("done_div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
            check("done_not_busy", 32'(busy), 32'd0);
         end else if (!busy) begin
            check("idle_quotient", quotient, 32'd0);
            check("idle_remainder", remainder, 32'd0);
            check("idle_div_by_zero", 32'(div_by_zero), 32'd0);
         end
      end
   end

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_op_done"}, 32'(op_done), 32'd0);
      check({tag, "_quotient"}, quotient, 32'd0);
      check({tag, "_remainder"}, remainder, 32'd0);
      check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
   endtask

   // One operation; restart_at/clear_at/rst_at name the counter value at which
   // that event is injected (-1 = none); lit_* are hand-computed results
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int restart_at, input int clear_at, input int rst_at,
                         input logic lit_en, input logic [31:0] lit_q, input logic [31:0] lit_r);
      logic [31:0] mq;
      logic [31:0] mr;
      logic        mz;
      int          n;
      int          busy_n;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      op_start = 1'b1;
      model(a, b, mq, mr, mz);
      exp_q     = mq;
      exp_r     = mr;
      exp_dbz   = mz;
      exp_valid = 1'b1;
      if (lit_en) begin
         check({tag, "_model_q"}, mq, lit_q);
         check({tag, "_model_r"}, mr, lit_r);
      end
      @(posedge clk);
      #1;
      op_start = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (b == 32'd0) begin
         check({tag, "_dbz_done_after_start"}, 32'(op_done), 32'd1);
         check({tag, "_dbz_not_busy"}, 32'(busy), 32'd0);
      end else begin
         check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
         busy_n = 1;
         n = 0;
         while (n < 40) begin
            op_start = (n == restart_at);
            if (n == restart_at) begin
               dividend = $urandom;
               divisor  = $urandom | 32'd1;
            end
            if (n == clear_at) op_clear = 1'b1;
            if (n == rst_at) begin
               reset_n = 1'b0;
               #1;
               check_cleared({tag, "_async_reset"});
               reset_n   = 1'b1;
               exp_valid = 1'b0;
               return;
            end
            @(posedge clk);
            #1;
            n++;
            if (n - 1 == clear_at) begin
               op_clear = 1'b0;
               check_cleared({tag, "_abort"});
               exp_valid = 1'b0;
               return;
            end
            if (op_done) break;
            if (busy) busy_n++;
         end
         op_start = 1'b0;
         check({tag, "_latency"}, 32'(n), 32'd32);
         check({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
      end
      check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(b == 32'd0));
      if (lit_en) begin
         check({tag, "_quotient"}, quotient, lit_q);
         check({tag, "_remainder"}, remainder, lit_r);
      end
      op_clear = 1'b1;
      @(posedge clk);
      #1;
      op_clear = 1'b0;
      check_cleared({tag, "_ack"});
      exp_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Clear outranks start in idle
      @(negedge clk);
      dividend = 32'd9;
      divisor  = 32'd3;
      op_start = 1'b1;
      op_clear = 1'b1;
      @(posedge clk);
      #1;
      op_start = 1'b0;
      op_clear = 1'b0;
      check_cleared("clear_over_start");

      run_op("u100_7", 32'd100, 32'd7, -1, -1, -1, 1'b1, 32'd14, 32'd2);
      run_op("dbz5", 32'd5, 32'd0, -1, -1, -1, 1'b1, 32'hFFFF_FFFF, 32'd5);
`ifdef DIV_SIGNED_EN
      run_op("m7_2", 32'hFFFF_FFF9, 32'd2, -1, -1, -1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op("p7_m2", 32'd7, 32'hFFFF_FFFE, -1, -1, -1, 1'b1, 32'hFFFF_FFFD, 32'd1);
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 1'b1, 32'h8000_0000, 32'd0);
`else
      run_op("m7_2", 32'hFFFF_FFF9, 32'd2, -1, -1, -1, 1'b1, 32'h7FFF_FFFC, 32'd1);
      run_op("p7_m2", 32'd7, 32'hFFFF_FFFE, -1, -1, -1, 1'b1, 32'd0, 32'd7);
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 1'b1, 32'd0, 32'h8000_0000);
`endif
      run_op("all_ones_1", 32'hFFFF_FFFF, 32'd1, -1, -1, -1, 1'b1, 32'hFFFF_FFFF, 32'd0);
      run_op("zero_5", 32'd0, 32'd5, -1, -1, -1, 1'b1, 32'd0, 32'd0);
      run_op("small_big", 32'd7, 32'd100, -1, -1, -1, 1'b1, 32'd0, 32'd7);
      run_op("equal", 32'd12345, 32'd12345, -1, -1, -1, 1'b1, 32'd1, 32'd0);
      run_op("reset_mid", 32'd1234, 32'd5, -1, -1, 10, 1'b0, 32'd0, 32'd0);
      run_op("restart_ign", 32'd1000, 32'd3, 5, -1, -1, 1'b1, 32'd333, 32'd1);
      run_op("clear_mid", 32'd999, 32'd9, -1, 20, -1, 1'b0, 32'd0, 32'd0);
      run_op("after_clear", 32'd1000, 32'd10, -1, -1, -1, 1'b1, 32'd100, 32'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
